// File: rtl/phase_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// phase_accumulator_pkg
// Shared definitions for the phase-accumulator (NCO) block: default widths,
// FSM state encoding and the dither LFSR polynomial/seed.
// ---------------------------------------------------------------------------
package phase_accumulator_pkg;

    localparam int ACC_W_DEF  = 16;
    localparam int ADDR_W_DEF = 8;
    localparam int FTW_W_DEF  = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

    // x^8+x^6+x^5+x^4+1 in right-shifting Galois form (bits 7,5,4,3)
    localparam logic [7:0] LFSR_POLY = 8'hB8;
    localparam logic [7:0] LFSR_SEED = 8'h01;

endpackage

// File: rtl/phase_accumulator_lfsr.sv
// ---------------------------------------------------------------------------
// phase_dither_lfsr
// 8-bit Galois LFSR used to dither the truncated phase when forming the
// table address. Advances once per enabled cycle; never reaches zero
// because it is seeded non-zero.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset (loads LFSR_SEED)
//   en   in   advance one state
//   q    out  current LFSR value
// ---------------------------------------------------------------------------
module phase_dither_lfsr
    import phase_accumulator_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= {1'b0, q[7:1]} ^ (q[0] ? LFSR_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/phase_accumulator.sv
// ---------------------------------------------------------------------------
// phase_accumulator
// NCO stage producing the waveform-table address. The phase advances by the
// shadowed tuning word once per PWM period; new tuning words are taken only
// at phase wrap (phase-continuous), and any waveform-select change restarts
// the phase at 0.
//
// Optional feature: define PHASE_DITHER_EN to add LFSR dither to the bits
// just below the address before truncation (acc itself is never dithered).
// Dither requires ACC_W - ADDR_W >= 8.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   period_start  in   one-cycle strobe at each PWM period start
//   ftw           in   frequency tuning word (phase step per period)
//   sel           in   waveform select; any change restarts the phase
//   addr          out  registered table address
//   addr_valid    out  one-cycle pulse when addr was just updated
//   wrap          out  one-cycle pulse when the last step overflowed
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | ftw_q == 0; reload ftw every cycle, no steps or pulses
// ST_RUN    | step acc by ftw_q on each period_start
// ST_RESYNC | cycle after a sel change; phase already zeroed, no step
// ---------------------------------------------------------------------------
module phase_accumulator
    import phase_accumulator_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int FTW_W  = FTW_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              period_start,
    input  logic [FTW_W-1:0]  ftw,
    input  logic [1:0]        sel,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic              wrap
);

    logic [ACC_W-1:0] acc;
    logic [FTW_W-1:0] ftw_q;
    logic [1:0]       sel_q;
    state_t           state;

    logic             sel_change;
    logic             step;
    logic [ACC_W:0]   sum;
    logic [ADDR_W-1:0] addr_step;

    assign sel_change = (sel != sel_q);
    // a sel change in the same cycle as a strobe wins and drops the step
    assign step       = (state == ST_RUN) && period_start && !sel_change;
    assign sum        = {1'b0, acc} + {{(ACC_W + 1 - FTW_W){1'b0}}, ftw_q};

`ifdef PHASE_DITHER_EN
    logic [7:0] lfsr_q;
    logic [8:0] dith_sum;

    phase_dither_lfsr u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (step),
        .q   (lfsr_q)
    );

    // dither is added to the 8 bits below the address; its carry bumps the
    // address but is never written back into acc
    assign dith_sum  = {1'b0, sum[ACC_W-ADDR_W-1 -: 8]} + {1'b0, lfsr_q};
    assign addr_step = sum[ACC_W-1 -: ADDR_W] + ADDR_W'(dith_sum[8]);
`else
    assign addr_step = sum[ACC_W-1 -: ADDR_W];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            ftw_q      <= '0;
            sel_q      <= '0;
            state      <= ST_IDLE;
            addr       <= '0;
            addr_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            addr_valid <= 1'b0;
            wrap       <= 1'b0;
            if (sel_change) begin
                // phase restart becomes visible in the following cycle
                sel_q      <= sel;
                acc        <= '0;
                addr       <= '0;
                addr_valid <= 1'b1;
                ftw_q      <= ftw;
                state      <= ST_RESYNC;
            end else begin
                case (state)
                    ST_IDLE: begin
                        ftw_q <= ftw;
                        if (ftw != '0) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (step) begin
                            acc        <= sum[ACC_W-1:0];
                            addr       <= addr_step;
                            addr_valid <= 1'b1;
                            wrap       <= sum[ACC_W];
                            if (sum[ACC_W]) begin
                                ftw_q <= ftw;
                                if (ftw == '0) begin
                                    state <= ST_IDLE;
                                end
                            end
                        end
                    end
                    ST_RESYNC: begin
                        state <= (ftw_q != '0) ? ST_RUN : ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
